// File: rtl/hopfield_pkg.sv
// Shared types, constants and saturation helpers for the time-multiplexed
// Hopfield/Izhikevich core. Neuron state values are 16-bit signed integers (mV).
package hopfield_pkg;

  localparam int STATE_W = 16;

  typedef logic signed [STATE_W-1:0] nval_t;

  localparam nval_t V_RESET = -16'sd65;
  localparam nval_t U_RESET = -16'sd16;
  localparam nval_t V_PEAK  = 16'sd30;
  localparam nval_t U_JUMP  = 16'sd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_UPDATE,
    S_COMMIT
  } fsm_e;

  // Clamp a 32-bit intermediate into the 16-bit state range.
  function automatic nval_t sat16(input logic signed [31:0] x);
    if (x > 32'sd32767) return 16'sh7fff;
    if (x < -32'sd32768) return 16'sh8000;
    return x[15:0];
  endfunction

  // Clamp into a ww-bit signed weight range; result is sign-extended to 16 bits.
  function automatic nval_t wsat(input logic signed [31:0] x, input int ww);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (ww - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi[15:0];
    if (x < lo) return lo[15:0];
    return x[15:0];
  endfunction

endpackage

// File: rtl/hopfield_tm_core_izh_step.sv
// One Izhikevich integration step in integer mV, purely combinational.
// Intermediates are 32-bit signed; stored results saturate to 16 bits.
module izh_step
  import hopfield_pkg::*;
(
  input  nval_t v,
  input  nval_t u,
  input  nval_t i_cur,
  output nval_t vn,
  output nval_t un,
  output logic  spike
);

  logic signed [31:0] v32;
  logic signed [31:0] u32;
  logic signed [31:0] i32;
  logic signed [31:0] dv;
  logic signed [31:0] vn_raw;
  logic signed [31:0] un_raw;

  // Membrane and recovery update, spike detection and post-spike reset.
  always_comb begin
    v32    = 32'(v);
    u32    = 32'(u);
    i32    = 32'(i_cur);
    dv     = ((v32 * v32 * 32'sd41) >>> 10) + (32'sd5 * v32) + 32'sd140 - u32 + i32;
    vn_raw = v32 + (dv >>> 1);
    un_raw = u32 + (((v32 >>> 2) - u32) >>> 6);
    spike  = 1'b0;
    if (vn_raw >= 32'(V_PEAK)) begin
      spike  = 1'b1;
      vn_raw = 32'(V_RESET);
      un_raw = un_raw + 32'(U_JUMP);
    end
    vn = sat16(vn_raw);
    un = sat16(un_raw);
  end

endmodule

// File: rtl/hopfield_tm_core.sv
// Time-multiplexed Hopfield/Izhikevich network core. One shared neuron
// datapath visits N neurons per sweep: N MAC cycles of recurrent input from
// the previous sweep's spikes (with optional Hebbian weight training), then
// one update cycle, then a single commit cycle that publishes the spikes.
// Optional debug weight readout port: define HOPFIELD_WREAD_EN.
module hopfield_tm_core
  import hopfield_pkg::*;
#(
  parameter int                 N           = 7,
  parameter int                 WW          = 8,
  parameter logic signed [15:0] DRIVE       = 16'sd10,
  parameter logic signed [15:0] LEARN_BOOST = 16'sd20,
  localparam int                IW          = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          learn_en,
  input  logic [N-1:0]  pattern_in,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  spikes
`ifdef HOPFIELD_WREAD_EN
  ,
  input  logic [IW-1:0] w_row,
  input  logic [IW-1:0] w_col,
  output logic [WW-1:0] w_rdata
`endif
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  fsm_e                 state_q, state_d;
  logic [IW-1:0]        i_q, i_d;
  logic [IW-1:0]        j_q, j_d;
  nval_t                acc_q, acc_d;
  logic [N-1:0]         pat_q, pat_d;
  logic                 learn_q, learn_d;
  logic [N-1:0]         nxt_q, nxt_d;
  logic [N-1:0]         spikes_q, spikes_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic signed [WW-1:0] w_q [N][N];
  logic signed [WW-1:0] w_d [N][N];
  nval_t                v_q [N];
  nval_t                v_d [N];
  nval_t                u_q [N];
  nval_t                u_d [N];

  logic signed [31:0]   w_ext;
  nval_t                i_cur;
  nval_t                izh_vn;
  nval_t                izh_un;
  logic                 izh_spike;

  assign w_ext = 32'(w_q[i_q][j_q]);

  // Total input current for the neuron being updated.
  always_comb begin
    i_cur = sat16(32'(acc_q)
                  + (pat_q[i_q] ? 32'(DRIVE) : 32'sd0)
                  + ((learn_q && pat_q[i_q]) ? 32'(LEARN_BOOST) : 32'sd0));
  end

  izh_step u_izh (
    .v    (v_q[i_q]),
    .u    (u_q[i_q]),
    .i_cur(i_cur),
    .vn   (izh_vn),
    .un   (izh_un),
    .spike(izh_spike)
  );

  // Sweep sequencing, MAC accumulation, Hebbian training and neuron writeback.
  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave a value unassigned and infer a latch.
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    pat_d    = pat_q;
    learn_d  = learn_q;
    nxt_d    = nxt_q;
    spikes_d = spikes_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    w_d      = w_q;
    v_d      = v_q;
    u_d      = u_q;

    unique case (state_q)
      S_IDLE: begin
        if (step) begin
          pat_d   = pattern_in;
          learn_d = learn_en;
          busy_d  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = sat16(32'(acc_q) + (spikes_q[j_q] ? w_ext : 32'sd0));
        // Self-connections are never trained; training reads last sweep's spikes.
        if (learn_q && (i_q != j_q)) begin
          if (spikes_q[i_q] && spikes_q[j_q]) begin
            w_d[i_q][j_q] = WW'(wsat(w_ext + 32'sd1, WW));
          end else if (spikes_q[i_q] != spikes_q[j_q]) begin
            w_d[i_q][j_q] = WW'(wsat(w_ext - 32'sd1, WW));
          end
        end
        if (j_q == LAST) begin
          state_d = S_UPDATE;
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      S_UPDATE: begin
        v_d[i_q]   = izh_vn;
        u_d[i_q]   = izh_un;
        nxt_d[i_q] = izh_spike;
        acc_d      = '0;
        if (i_q == LAST) begin
          state_d = S_COMMIT;
        end else begin
          i_d     = i_q + IW'(1);
          j_d     = '0;
          state_d = S_ACCUM;
        end
      end
      S_COMMIT: begin
        spikes_d = nxt_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      pat_q    <= '0;
      learn_q  <= 1'b0;
      nxt_q    <= '0;
      spikes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      // NOTE: the register files are flops, not RAM, so weights and neuron state can clear on reset.
      for (int k = 0; k < N; k++) begin
        v_q[k] <= V_RESET;
        u_q[k] <= U_RESET;
        for (int m = 0; m < N; m++) begin
          w_q[k][m] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      pat_q    <= pat_d;
      learn_q  <= learn_d;
      nxt_q    <= nxt_d;
      spikes_q <= spikes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      v_q      <= v_d;
      u_q      <= u_d;
      w_q      <= w_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign spikes = spikes_q;

`ifdef HOPFIELD_WREAD_EN
  // Debug readout of one weight; indices beyond N-1 read as zero.
  always_comb begin
    w_rdata = '0;
    if ((32'(w_row) < N) && (32'(w_col) < N)) begin
      w_rdata = w_q[w_row][w_col];
    end
  end
`endif

endmodule

// File: doc/hopfield_tm_core.md
Name: hopfield_tm_core

Overview:
- Parametrised, time-multiplexed Hopfield/Izhikevich network core.
- A single shared neuron datapath sweeps N neurons and keeps per-neuron v/u state in internal register files, so no state is lost between visits.
- Each neuron gets a recurrent current: the weighted sum of the previous sweep's spikes, accumulated one MAC per cycle.
- Weights are on-chip and optionally trained with a saturating Hebbian rule during the same pass. The block sits between pattern I/O and the spike output pins.

Parameters:
- N, 7, neuron count (2..16).
- WW, 8, signed weight width.
- DRIVE, 16'sd10, external current when pattern bit is set.
- LEARN_BOOST, 16'sd20, extra current on set pattern bits while learning.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step  in  1  request one full network sweep; accepted only in IDLE.
- learn_en  in  1  Hebbian update enable; sampled on step acceptance.
- pattern_in  in  N  external drive pattern; sampled on step acceptance.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse when a sweep commits.
- spikes  out  N  spike vector of the last completed sweep.

Behaviour:
- Reset values (asynchronous, reset high):
  - busy=0, done=0, spikes=0, FSM=IDLE.
  - All weights=0; every neuron v=-65, u=-16.
  - Counters i, j and the accumulator are 0.
- FSM states:
  - IDLE: step=1 latches pattern_in and learn_en, sets busy, clears i, j, acc, and moves to ACCUM.
  - ACCUM, cycle j (0..N-1): acc += spikes[j] ? w[i][j] : 0, sign-extended to 16 bits, saturating at ±32767/-32768.
    - If latched learn_en=1 and i!=j, w[i][j] is updated in the same cycle using spikes (previous sweep):
      - both set: +1, saturating at 2^(WW-1)-1;
      - exactly one set: -1, saturating at -2^(WW-1);
      - neither set: unchanged.
    - w[i][i] is never written. At j=N-1, go to UPDATE.
  - UPDATE (1 cycle):
    - I = sat16(acc + (pat[i] ? DRIVE : 0) + (learn & pat[i] ? LEARN_BOOST : 0)).
    - The izh_step result is written to v[i] and u[i]; the spike bit goes to next_spk[i]; acc is cleared.
    - If i==N-1, go to COMMIT; else i++, j=0, go to ACCUM.
  - COMMIT (1 cycle): spikes<=next_spk, done=1, busy=0, go to IDLE.
- Latency: step accepted at cycle 0 → done at cycle N*(N+1)+1 (57 for N=7). spikes changes only in the COMMIT cycle.
- All neurons in a sweep see the previous sweep's spikes (synchronous Hopfield update).
- step while busy is ignored, not queued. step in the COMMIT cycle is ignored. step in the cycle after done is accepted.
- izh_step arithmetic (integer mV, signed, 32-bit internally):
  - dv = ((v*v*41)>>>10) + 5v + 140 - u + I; vn = v + (dv>>>1).
  - un = u + (((v>>>2) - u)>>>6).
  - If vn ≥ 30: spike=1, vn=-65, un=un+8.
  - Store vn and un saturated to 16 bits.
- Reset mid-sweep aborts immediately. No done pulse is produced, and weights and spikes return to 0.

Optional Feature:
- Macro: HOPFIELD_WREAD_EN.
- Defined: adds input w_row[$clog2(N)-1:0], input w_col[$clog2(N)-1:0] and output w_rdata[WW-1:0].
  - w_rdata is a combinational read of w[w_row][w_col] for debug/readout.
  - Out-of-range indices read 0.
- Undefined: the ports are absent. Behaviour is otherwise identical.

Decomposition:
- Package hopfield_pkg holds:
  - constants V_RESET=-65, U_RESET=-16, V_PEAK=30, U_JUMP=8;
  - the state width (16);
  - sat16 and weight-saturate functions.
- Sub-module izh_step (purely combinational): inputs v, u, I; outputs vn, un, spike.
- The FSM, register files and Hebbian logic stay in hopfield_tm_core.

Test Plan:
- Reset → spikes=0, busy=0, all w=0 (via HOPFIELD_WREAD_EN), v=-65. Release reset, then 100 sweeps with pattern_in=0 → no spikes, and every done arrives exactly 57 cycles after its step (N=7).
- pattern_in=7'b0000001, learn_en=0, repeated sweeps → only neuron 0 eventually spikes; every other spikes bit stays 0 and weights stay 0.
- Hebbian rule: force spikes=7'b0000011 via prior sweeps, then sweep with learn_en=1:
  - w[0][1] and w[1][0] each +1;
  - w[0][2] -1;
  - w[2][3] unchanged;
  - w[0][0] stays 0.
  - Repeat 200 sweeps → weights clip at +127 / -128 with no wrap.
- step held high across a whole sweep → exactly one sweep per IDLE entry, with done pulses 58 cycles apart. A step pulse during busy does not extend the sweep or create an extra done.
- Assert reset at ACCUM i=3, j=2 → busy, done and spikes go to 0 the same cycle and weights clear. The next step runs a clean sweep.
- Recall: train pattern 7'b0101010 for 50 sweeps, then drive the corrupted 7'b0101000 with learn_en=0 → within 20 sweeps spikes matches the stored pattern's active set (bit 1 recovered).
